// File: rtl/result_readout_if.sv
// Byte-stream link from the result reader to the HPS/UART bridge.
// A byte moves on a rising clk edge where tx_valid && tx_ready are both high;
// once tx_valid is raised it stays high and tx_data/tx_last stay fixed until that edge.
interface result_readout_if #(
  parameter int W = 8
);
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         tx_last;

  modport master (output tx_data, tx_valid, tx_last, input tx_ready);
  modport slave  (input tx_data, tx_valid, tx_last, output tx_ready);
endinterface

// File: rtl/result_readout.sv
// Latches the winning core/key when the search finishes and streams a framed result:
// success = 'S', key[23:0] MSB first, 32 message bytes; fail = single 'F' byte.
module result_readout #(
  parameter int NUM_CORES          = 2,
  parameter int LOG_NUM_CORES      = 8,
  parameter int MESSAGE_LENGTH     = 32,
  parameter int MESSAGE_LOG_LENGTH = 5,
  parameter int RAM_WIDTH          = 8,
  parameter int KEY_WIDTH          = 24
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          finish,
  input  logic                          success,
  input  logic                          fail,
  input  logic [LOG_NUM_CORES-1:0]      core_sel,
  input  logic [KEY_WIDTH-1:0]          key_in,
  output logic [LOG_NUM_CORES-1:0]      rd_core,
  output logic [MESSAGE_LOG_LENGTH-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0]          a_q,
  result_readout_if.master              tx,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    o_dbg_state
);

  localparam int IDX_W = MESSAGE_LOG_LENGTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MESSAGE_LENGTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_KEY, S_FETCH, S_WAIT, S_MSG, S_DONE
  } state_t;

  state_t                   r_state, w_next;
  logic                     r_finish_q;
  logic [LOG_NUM_CORES-1:0] r_rd_core;
  logic [KEY_WIDTH-1:0]     r_key;
  logic                     r_kind_ok;
  logic [1:0]               r_kcnt;
  logic [IDX_W-1:0]         r_idx;
  logic [RAM_WIDTH-1:0]     r_byte;

  logic w_trigger, w_accept, w_core_ok, w_kind_ok, w_msg_last;

  assign w_trigger  = finish && !r_finish_q;
  assign w_accept   = tx.tx_valid && tx.tx_ready;
  assign w_core_ok  = core_sel < LOG_NUM_CORES'(NUM_CORES);
  assign w_msg_last = (r_idx == LAST_IDX);

  // success wins over a simultaneous fail; neither flag set also yields a fail frame
  always_comb begin
    casez ({success, fail})
      2'b1?:   w_kind_ok = w_core_ok;
      2'b01:   w_kind_ok = 1'b0;
      default: w_kind_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_finish_q <= 1'b1;
      r_rd_core  <= '0;
      r_key      <= '0;
      r_kind_ok  <= 1'b0;
      r_kcnt     <= '0;
      r_idx      <= '0;
      r_byte     <= '0;
    end else begin
      r_state    <= w_next;
      r_finish_q <= finish;
      if (r_state == S_IDLE && w_trigger) begin
        r_rd_core <= core_sel;
        r_key     <= key_in;
        r_kind_ok <= w_kind_ok;
        r_kcnt    <= '0;
        r_idx     <= '0;
      end
      if (r_state == S_KEY && w_accept) r_kcnt <= r_kcnt + 2'd1;
      if (r_state == S_WAIT) r_byte <= a_q;
      // idx returns to 0 at frame end so the address port rests at 0 between frames
      if (r_state == S_MSG && w_accept) r_idx <= w_msg_last ? '0 : r_idx + IDX_W'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    tx.tx_valid = 1'b0;
    tx.tx_last  = 1'b0;
    tx.tx_data  = '0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (w_trigger) w_next = S_HDR;
      S_HDR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = r_kind_ok ? RAM_WIDTH'(8'h53) : RAM_WIDTH'(8'h46);
        tx.tx_last  = !r_kind_ok;
        if (w_accept) w_next = r_kind_ok ? S_KEY : S_DONE;
      end
      S_KEY: begin
        tx.tx_valid = 1'b1;
        case (r_kcnt)
          2'd0:    tx.tx_data = r_key[KEY_WIDTH-1 -: RAM_WIDTH];
          2'd1:    tx.tx_data = r_key[KEY_WIDTH-RAM_WIDTH-1 -: RAM_WIDTH];
          default: tx.tx_data = r_key[RAM_WIDTH-1:0];
        endcase
        if (w_accept && r_kcnt == 2'd2) w_next = S_FETCH;
      end
      S_FETCH: w_next = S_WAIT;
      S_WAIT:  w_next = S_MSG;
      S_MSG: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = r_byte;
        tx.tx_last  = w_msg_last;
        if (w_accept) w_next = w_msg_last ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign rd_core     = r_rd_core;
  assign a_addr      = r_idx[MESSAGE_LOG_LENGTH-1:0];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_result_readout.sv
// Directed + randomized bench for result_readout; frames are checked against a
// reference built from the frame format and a behavioural A-RAM model.
module tb_result_readout;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        finish = 1'b1;
  logic        success = 1'b0;
  logic        fail = 1'b0;
  logic [7:0]  core_sel = '0;
  logic [23:0] key_in = '0;
  logic [7:0]  rd_core;
  logic [4:0]  a_addr;
  logic [7:0]  a_q = '0;
  logic        busy, done;
  logic [2:0]  dbg_state;

  result_readout_if #(.W(8)) tx_if ();

  result_readout dut (
    .clk(clk), .reset(reset), .finish(finish), .success(success), .fail(fail),
    .core_sel(core_sel), .key_in(key_in), .rd_core(rd_core), .a_addr(a_addr),
    .a_q(a_q), .tx(tx_if), .busy(busy), .done(done), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // A-RAM model: one-cycle read latency, one bank per core
  logic [7:0] mem [2][32];
  always @(posedge clk) a_q <= (rd_core < 8'd2) ? mem[rd_core[0]][a_addr] : 8'h00;

  bit ready_rand = 1'b0;
  initial tx_if.tx_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    tx_if.tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // sink monitor
  logic [7:0] rx_q[$];
  bit         rx_last_q[$];
  int         acc_q[$];
  int         done_cnt = 0;
  int         done_cyc = 0;
  bit         addr_nonzero = 1'b0;
  bit         prev_stall = 1'b0;
  logic [7:0] prev_data;
  logic       prev_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(tx_if.tx_valid), 32'd1);
        check("stall_data", 32'(tx_if.tx_data), 32'(prev_data));
        check("stall_last", 32'(tx_if.tx_last), 32'(prev_last));
      end
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        rx_q.push_back(tx_if.tx_data);
        rx_last_q.push_back(tx_if.tx_last);
        acc_q.push_back(cyc + 1);
      end
      prev_stall = tx_if.tx_valid && !tx_if.tx_ready;
      prev_data  = tx_if.tx_data;
      prev_last  = tx_if.tx_last;
      if (a_addr != 5'd0) addr_nonzero = 1'b1;
      if (done) begin
        done_cnt++;
        done_cyc = cyc + 1;
      end
    end
  end

  logic [7:0] exp_q[$];

  // reference frame built straight from the frame format
  task automatic build_expected(input logic s, input logic [7:0] core, input logic [23:0] key);
    exp_q.delete();
    if (s && core < 8'd2) begin
      exp_q.push_back(8'h53);
      exp_q.push_back(key[23:16]);
      exp_q.push_back(key[15:8]);
      exp_q.push_back(key[7:0]);
      for (int i = 0; i < 32; i++) exp_q.push_back(mem[core[0]][i]);
    end else begin
      exp_q.push_back(8'h46);
    end
  endtask

  task automatic clear_rx();
    rx_q.delete();
    rx_last_q.delete();
    acc_q.delete();
    addr_nonzero = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input string tag);
    int n;
    n = 0;
    while (done_cnt == start_cnt && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt > start_cnt), 32'd1);
  endtask

  // issues a rising finish edge; returns the trigger cycle
  task automatic run_frame(input logic s, input logic f, input logic [7:0] core,
                           input logic [23:0] key, input bit rnd, input string tag,
                           output int t_trig);
    int start_cnt;
    clear_rx();
    @(posedge clk); #1;
    finish = 1'b0;
    @(posedge clk); #1;
    success = s; fail = f; core_sel = core; key_in = key;
    finish = 1'b1;
    t_trig = cyc + 1;
    start_cnt = done_cnt;
    ready_rand = rnd;
    @(posedge clk); #1;
    // inputs change after the trigger; the latched values must not follow them
    core_sel = 8'($urandom_range(0, 3));
    key_in = 24'($urandom);
    success = 1'($urandom_range(0, 1));
    wait_done(start_cnt, tag);
    ready_rand = 1'b0;
  endtask

  task automatic check_frame(input string tag, input logic s, input logic [7:0] core,
                             input logic [23:0] key);
    build_expected(s, core, key);
    check({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(rx_q[i]), 32'(exp_q[i]));
      check($sformatf("%s_last%0d", tag, i), 32'(rx_last_q[i]), 32'(i == exp_q.size() - 1));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int snap;
    int dsnap;
    logic [23:0] k;
    logic [7:0]  c;

    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 32; i++) mem[b][i] = 8'($urandom);
    for (int i = 0; i < 32; i++) mem[1][i] = 8'(8'h61 + i);

    // reset with finish already high: nothing may start
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("rst_tx_last", 32'(tx_if.tx_last), 32'd0);
    check("rst_tx_data", 32'(tx_if.tx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_a_addr", 32'(a_addr), 32'd0);
    check("rst_rd_core", 32'(rd_core), 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("no_trig_after_rst_busy", 32'(busy), 32'd0);
    check("no_trig_after_rst_bytes", 32'(rx_q.size()), 32'd0);

    // scenario 1: success, core 1, key 0x3FFFFF, ready always high; exact timing
    run_frame(1'b1, 1'b0, 8'd1, 24'h3FFFFF, 1'b0, "s1", t);
    check_frame("s1", 1'b1, 8'd1, 24'h3FFFFF);
    if (acc_q.size() == 36) begin
      for (int i = 0; i < 4; i++) check($sformatf("s1_hdrcyc%0d", i), 32'(acc_q[i] - t), 32'(i + 1));
      for (int i = 0; i < 32; i++) check($sformatf("s1_msgcyc%0d", i), 32'(acc_q[4 + i] - t), 32'(7 + 3 * i));
    end
    check("s1_done_cyc", 32'(done_cyc - t), 32'd101);
    check("s1_rd_core", 32'(rd_core), 32'd1);
    @(negedge clk);
    check("s1_done_pulse_len", 32'(done), 32'd0);
    check("s1_idle_busy", 32'(busy), 32'd0);

    // scenario 2: fail frame
    run_frame(1'b0, 1'b1, 8'd0, 24'h123456, 1'b0, "s2", t);
    check_frame("s2", 1'b0, 8'd0, 24'h123456);
    check("s2_done_cyc", 32'(done_cyc - t), 32'd2);
    check("s2_addr_zero", 32'(addr_nonzero), 32'd0);

    // scenario 3: same success frame under random back-pressure
    run_frame(1'b1, 1'b0, 8'd1, 24'h3FFFFF, 1'b1, "s3", t);
    check_frame("s3", 1'b1, 8'd1, 24'h3FFFFF);
    check("s3_accepts", 32'(acc_q.size()), 32'd36);

    // scenario 4: out-of-range core with success -> fail frame
    run_frame(1'b1, 1'b0, 8'd2, 24'hABCDEF, 1'b0, "s4", t);
    check_frame("s4", 1'b1, 8'd2, 24'hABCDEF);
    check("s4_rd_core", 32'(rd_core), 32'd2);

    // success and fail both high: success wins; neither high: fail frame
    run_frame(1'b1, 1'b1, 8'd0, 24'h0F1E2D, 1'b0, "s4b", t);
    check_frame("s4b", 1'b1, 8'd0, 24'h0F1E2D);
    run_frame(1'b0, 1'b0, 8'd1, 24'h777777, 1'b0, "s4c", t);
    check_frame("s4c", 1'b0, 8'd1, 24'h777777);

    // randomized frames against the reference
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 32; i++) mem[b][i] = 8'($urandom);
      k = 24'($urandom);
      c = 8'($urandom_range(0, 2));
      run_frame(1'b1, 1'($urandom_range(0, 1)), c, k, 1'b1, $sformatf("rnd%0d", r), t);
      check_frame($sformatf("rnd%0d", r), 1'b1, c, k);
      check($sformatf("rnd%0d_rd_core", r), 32'(rd_core), 32'(c));
    end

    // scenario 5: reset while message byte 10 is presented
    clear_rx();
    @(posedge clk); #1;
    finish = 1'b0;
    @(posedge clk); #1;
    success = 1'b1; fail = 1'b0; core_sel = 8'd0; key_in = 24'h010203;
    finish = 1'b1;
    t = 0;
    dsnap = done_cnt;
    while (!(tx_if.tx_valid && a_addr == 5'd10 && rx_q.size() >= 14) && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    check("s5_reached_byte10", 32'(t < 500), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("s5_rst_tx_valid", 32'(tx_if.tx_valid), 32'd0);
    check("s5_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    snap = rx_q.size();
    repeat (20) @(posedge clk);
    #1;
    check("s5_no_done", 32'(done_cnt), 32'(dsnap));
    check("s5_no_restart_busy", 32'(busy), 32'd0);
    check("s5_no_new_bytes", 32'(rx_q.size()), 32'(snap));
    run_frame(1'b1, 1'b0, 8'd0, 24'h010203, 1'b0, "s5r", t);
    check_frame("s5r", 1'b1, 8'd0, 24'h010203);

    // scenario 6: finish held high after done -> no re-trigger
    snap = done_cnt;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      success = ~success;
    end
    check("s6_no_retrigger_busy", 32'(busy), 32'd0);
    check("s6_no_retrigger_done", 32'(done_cnt), 32'(snap));
    run_frame(1'b0, 1'b1, 8'd1, 24'h000000, 1'b0, "s6", t);
    check_frame("s6", 1'b0, 8'd1, 24'h000000);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/result_readout.md
Name: result_readout

Overview:
- Reader end of the key-search result path: once the search FSM raises finish, this block latches the winning core index and key.
- On success, it reads that core's decrypted-message RAM (A) byte by byte and streams a framed result over a valid/ready byte interface for the HPS or UART bridge. On fail, it sends a one-byte fail frame.
- Sits beside the parallel arcfour cores; drives the A-RAM read-port mux select and address.

Parameters:
- NUM_CORES, 2, number of arcfour cores.
- LOG_NUM_CORES, 8, width of core index.
- MESSAGE_LENGTH, 32, decrypted message bytes per core.
- MESSAGE_LOG_LENGTH, 5, A-RAM address width.
- RAM_WIDTH, 8, byte width.
- KEY_WIDTH, 24, key width (3 bytes).

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- finish  in  1  level; high while search FSM is in SUCCESS/FAIL/IDLE-finished state.
- success  in  1  search ended with a found key.
- fail  in  1  search exhausted without success.
- core_sel  in  LOG_NUM_CORES  index of first successful core.
- key_in  in  KEY_WIDTH  key of that core.
- rd_core  out  LOG_NUM_CORES  latched core index; external mux selects that core's A-RAM read port.
- a_addr  out  MESSAGE_LOG_LENGTH  A-RAM read address.
- a_q  in  RAM_WIDTH  A-RAM read data; valid exactly 1 cycle after a_addr presented.
- tx_data  out  RAM_WIDTH  stream byte.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  sink accepts when tx_valid && tx_ready at posedge.
- tx_last  out  1  marks final byte of frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset values:
  - State IDLE.
  - tx_valid=0, tx_last=0, tx_data=0, busy=0, done=0.
  - a_addr=0, rd_core=0.
  - finish_q=1, so a finish already high at reset does not trigger.
- Trigger: finish && !finish_q in IDLE. finish_q is the 1-cycle registered finish.
  - On trigger, latch core_sel→rd_core and key_in→key_reg.
  - Latch kind: success && core_sel<NUM_CORES → SUCCESS frame; otherwise (including both success and fail low) → FAIL frame.
  - success has priority over simultaneous fail.
- Edges while busy or in DONE are ignored. Re-arm requires finish to fall and rise again.
- States:
  - IDLE→HDR on trigger.
  - HDR: tx_valid=1, tx_data=0x53 for success, 0x46 for fail. tx_last=1 for fail. On accept: fail→DONE, success→KEY.
  - KEY: three bytes, key_reg[23:16], then [15:8], then [7:0]; tx_valid=1. After the third accept→FETCH with idx=0.
  - FETCH: tx_valid=0, a_addr=idx.
  - WAIT: tx_valid=0, a_addr held; capture a_q into tx_data at the end of the cycle.
  - MSG: tx_valid=1, tx_last=(idx==MESSAGE_LENGTH-1). On accept: if last→DONE, else idx++→FETCH.
  - DONE: done=1 for one cycle, busy=0→IDLE. The finish edge detector keeps running, so the next trigger needs a fresh rising edge.
- busy=1 in every state except IDLE.
- Handshake: while tx_valid && !tx_ready, tx_data and tx_last are held stable and tx_valid does not drop. The byte advances only on accept.
- Throughput with tx_ready=1: header, 3 key bytes, then 1 message byte per 3 cycles.
- idx is MESSAGE_LOG_LENGTH+1 bits wide, so MESSAGE_LENGTH=2^MESSAGE_LOG_LENGTH does not wrap early. a_addr=idx[MESSAGE_LOG_LENGTH-1:0].
- Reset mid-frame: next cycle IDLE, tx_valid=0. Partial frame is abandoned; no done pulse.
- rd_core and key_reg are held constant from trigger until the next trigger.

Test Plan:
- Reset, then finish rises at cycle T with success=1, core_sel=1, key_in=0x3FFFFF, A-RAM[i]=0x61+i, tx_ready=1 → bytes 0x53,0x3F,0xFF,0xFF at T+1..T+4; a_addr=0 at T+5; byte0=0x61 at T+7; byte i at T+7+3i; byte31=0x80 with tx_last at T+100; done at T+101; rd_core=1 throughout.
- Finish rises with fail=1, success=0 → single byte 0x46 with tx_last=1, done next cycle, a_addr never leaves 0.
- Success frame with tx_ready toggled 0/1 pseudo-randomly → tx_data/tx_last stable while stalled; received bytes identical to the first scenario; exactly 36 accepts.
- Success frame with core_sel=NUM_CORES (2) → fail frame 0x46.
- Reset asserted during message byte 10 → tx_valid=0 next cycle, busy=0, no done. finish held high after reset → no new frame until finish falls and rises again.
- finish held high after done, toggled success → no second frame; finish low 1 cycle then high → new frame starts.
